// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes cmd/addr bytes of each SPI frame and streams bytes to/from an 8-bit memory port
module spi_cmd_ctrl #(
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] CMD_WRITE  = 8'h53,
  parameter logic [7:0] CMD_READ   = 8'h4C,
  parameter logic [7:0] CMD_STATUS = 8'h3F
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sel,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_load,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy,
  output logic [7:0]        o_err_cnt
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, STATUS, DISCARD} state_t;
  state_t            r_state;
  logic [7:0]        r_tx_data, r_mem_wdata, r_err_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we, r_mem_re, r_busy, r_is_read, r_seen_low, r_rd_q, r_queued;
  logic [ADDR_W-1:0] w_rx_addr;
  assign w_rx_addr   = ADDR_W'(i_rx_data);
  assign o_tx_data   = r_tx_data;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;
  assign o_busy      = r_busy;
  assign o_err_cnt   = r_err_cnt;
  // r_seen_low blocks the tail of a frame interrupted by reset until sel has been low
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_tx_data   <= 8'h00;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_busy      <= 1'b0;
      r_err_cnt   <= 8'h00;
      r_is_read   <= 1'b0;
      r_seen_low  <= 1'b0;
      r_rd_q      <= 1'b0;
      r_queued    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      r_rd_q   <= r_mem_re;
      if (!i_sel) r_seen_low <= 1'b1;
      if (r_mem_we) r_mem_addr <= r_mem_addr + ADDR_W'(1);
      case (r_state)
        IDLE: if (i_sel && r_seen_low) begin
          r_state   <= CMD;
          r_busy    <= 1'b1;
          r_tx_data <= 8'hFF;
        end
        CMD: if (i_rx_valid) begin
          if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
            r_state   <= ADDR;
            r_is_read <= i_rx_data == CMD_READ;
          end else if (i_rx_data == CMD_STATUS) begin
            r_state   <= STATUS;
            r_tx_data <= {r_err_cnt[6:0], 1'b1};
          end else begin
            r_state   <= DISCARD;
            r_err_cnt <= r_err_cnt == 8'hFF ? 8'hFF : r_err_cnt + 8'd1;
          end
        end
        ADDR: if (i_rx_valid) begin
          r_mem_addr <= w_rx_addr;
          r_state    <= r_is_read ? READ : WRITE;
          r_mem_re   <= r_is_read;
        end
        WRITE: if (i_rx_valid) begin
          r_mem_wdata <= i_rx_data;
          r_mem_we    <= 1'b1;
        end
        READ: begin
          if (r_rd_q) begin
            r_tx_data  <= i_mem_rdata;
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
          end
          if (r_mem_re) begin
            if (i_tx_load) r_queued <= 1'b1;
          end else if (i_tx_load || r_queued) begin
            r_mem_re <= 1'b1;
            r_queued <= i_tx_load && r_queued;
          end
        end
        STATUS: if (i_tx_load) r_tx_data <= {r_err_cnt[6:0], 1'b1};
        default: ;
      endcase
      // frame end wins over any state transition; a coincident rx byte was still handled above
      if (!i_sel && r_state != IDLE) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_mem_re <= 1'b0;
        r_rd_q   <= 1'b0;
        r_queued <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed frames against spi_cmd_ctrl with a bench-side byte memory
module tb_spi_cmd_ctrl;
  logic       clk = 0, reset = 1, sel = 0, rx_valid = 0, tx_load = 0;
  logic [7:0] rx_data = 0, tx_data, mem_wdata, err_cnt, mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_we, mem_re, busy;
  int         n_vec = 0, n_err = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] we_addr [256], we_data [256], re_addr [256];
  int         we_n = 0, re_n = 0;

  always #5 clk = ~clk;

  spi_cmd_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_sel(sel),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .i_tx_load(tx_load),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_err_cnt(err_cnt)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]  <= mem_wdata;
      we_addr[we_n]  <= mem_addr;
      we_data[we_n]  <= mem_wdata;
      we_n           <= we_n + 1;
    end
    if (mem_re) begin
      mem_rdata      <= mem[mem_addr];
      re_addr[re_n]  <= mem_addr;
      re_n           <= re_n + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // one SPI byte: tx_load at byte start (captures MISO byte), rx_valid at byte end
  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    miso = tx_data;
    tx_load = 1;
    tick;
    tx_load = 0;
    repeat (7) tick;
    rx_data = mosi;
    rx_valid = 1;
    tick;
    rx_valid = 0;
    repeat (4) tick;
  endtask

  task automatic frame_start;
    sel = 1;
    repeat (2) tick;
  endtask

  task automatic frame_end;
    sel = 0;
    repeat (3) tick;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_addr"}, mem_addr, 8'h00);
    check({tag, "_wdata"}, mem_wdata, 8'h00);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_re"}, mem_re, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err_cnt"}, err_cnt, 8'h00);
  endtask

  initial begin
    logic [7:0] wd [8];
    logic [7:0] m;
    int w0, r0;
    wd = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    repeat (2) tick;
    check_reset_outputs("rst");
    reset = 0;
    repeat (2) tick;

    w0 = we_n; r0 = re_n;
    frame_start;
    xfer(8'h53, m);
    xfer(8'h10, m);
    check("busy_in_frame", busy, 1'b1);
    for (int i = 0; i < 8; i++) xfer(wd[i], m);
    check("wr_filler", m, 8'hFF);
    frame_end;
    check("busy_after_wr", busy, 1'b0);
    check("wr_count", we_n - w0, 8);
    for (int i = 0; i < 8; i++) begin
      check("wr_addr", we_addr[w0+i], 8'h10 + 8'(i));
      check("wr_data", we_data[w0+i], wd[i]);
    end
    check("wr_no_re", re_n - r0, 0);
    check("addr_after_wr", mem_addr, 8'h18);

    w0 = we_n; r0 = re_n;
    frame_start;
    xfer(8'h4C, m);
    xfer(8'h10, m);
    for (int i = 0; i < 8; i++) begin
      xfer(8'h00, m);
      check("rd_miso", m, wd[i]);
    end
    frame_end;
    check("rd_count", re_n - r0, 9);
    for (int i = 0; i < 9; i++) check("rd_addr", re_addr[r0+i], 8'h10 + 8'(i));
    check("rd_no_we", we_n - w0, 0);

    frame_start;
    xfer(8'h53, m);
    xfer(8'hFE, m);
    xfer(8'hAA, m);
    xfer(8'hBB, m);
    xfer(8'hCC, m);
    frame_end;
    check("wrap_fe", mem[8'hFE], 8'hAA);
    check("wrap_ff", mem[8'hFF], 8'hBB);
    check("wrap_00", mem[8'h00], 8'hCC);
    check("wrap_addr", mem_addr, 8'h01);

    w0 = we_n; r0 = re_n;
    frame_start;
    xfer(8'h99, m);
    xfer(8'h01, m);
    xfer(8'h02, m);
    check("discard_filler", m, 8'hFF);
    frame_end;
    check("bad_err_cnt", err_cnt, 8'h01);
    check("bad_no_we", we_n - w0, 0);
    check("bad_no_re", re_n - r0, 0);
    frame_start;
    xfer(8'h3F, m);
    xfer(8'h00, m);
    check("status_miso", m, 8'h03);
    frame_end;

    frame_start;
    xfer(8'h53, m);
    xfer(8'h20, m);
    xfer(8'h11, m);
    frame_end;
    check("abort_busy", busy, 1'b0);
    frame_start;
    xfer(8'h4C, m);
    xfer(8'h20, m);
    xfer(8'h00, m);
    check("abort_rd", m, 8'h11);
    frame_end;

    frame_start;
    xfer(8'h4C, m);
    xfer(8'h10, m);
    xfer(8'h00, m);
    check("pre_rst_rd0", m, 8'hA1);
    xfer(8'h00, m);
    check("pre_rst_rd1", m, 8'hB2);
    tx_load = 1;
    tick;
    tx_load = 0;
    repeat (3) tick;
    reset = 1;
    #1;
    check_reset_outputs("midrst");
    tick;
    reset = 0;
    w0 = we_n; r0 = re_n;
    repeat (3) tick;
    rx_data = 8'h00;
    rx_valid = 1;
    tick;
    rx_valid = 0;
    repeat (4) tick;
    xfer(8'h53, m);
    xfer(8'h40, m);
    xfer(8'h77, m);
    check("ignored_busy", busy, 1'b0);
    check("ignored_no_we", we_n - w0, 0);
    check("ignored_no_re", re_n - r0, 0);
    frame_end;

    w0 = we_n;
    frame_start;
    xfer(8'h53, m);
    xfer(8'h30, m);
    xfer(8'h5A, m);
    frame_end;
    check("post_rst_we_count", we_n - w0, 1);
    check("post_rst_we_addr", we_addr[w0], 8'h30);
    check("post_rst_we_data", we_data[w0], 8'h5A);
    frame_start;
    xfer(8'h4C, m);
    xfer(8'h30, m);
    xfer(8'h00, m);
    check("post_rst_rd", m, 8'h5A);
    frame_end;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind the `spi` byte engine. It decodes the first received byte of each chip-select frame as a command and the second as a start address. It then streams data bytes between the SPI byte interface and an 8-bit-wide local memory/register port, with auto-incrementing addresses. It is the only master of the memory port on the SPI side.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
CMD_WRITE, 8'h53, command: store following bytes to memory
CMD_READ, 8'h4C, command: return memory bytes on MISO
CMD_STATUS, 8'h3F, command: return status byte repeatedly

Ports:
clk  in  1  system clock, same domain as spi byte interface
reset  in  1  asynchronous, active-high
sel  in  1  frame active (synchronized inverse of spi_cs); low = idle
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  next byte for MISO
tx_load  in  1  one-cycle strobe: spi latched tx_data into shifter, next byte wanted
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  write data
mem_we  out  1  write strobe, one cycle
mem_re  out  1  read strobe, one cycle; mem_rdata valid the following cycle
mem_rdata  in  8  read data
busy  out  1  high while state != IDLE
err_cnt  out  8  count of unknown commands, saturating at 8'hFF

Behaviour:
- Reset values: tx_data=8'h00, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, err_cnt=0, state=IDLE.
- States: IDLE, CMD, ADDR, WRITE, READ, STATUS, DISCARD.
- IDLE -> CMD on sel rising (sel=1 while in IDLE).
- CMD, on rx_valid: rx_data==CMD_WRITE or CMD_READ -> ADDR, with the command latched. rx_data==CMD_STATUS -> STATUS. Any other value -> DISCARD, with err_cnt incremented (saturating).
- ADDR, on rx_valid: mem_addr <= rx_data[ADDR_W-1:0]. ADDR_W>8 zero-extends the upper bits. Next state is WRITE or READ according to the latched command.
- READ entry: mem_re pulses in the first READ cycle. The cycle after, tx_data <= mem_rdata and mem_addr increments.
- READ, on each tx_load: mem_re pulses the next cycle, then tx_data updates one cycle later. Fetch latency is 2 clk, which must be less than one SPI byte time.
- READ: tx_load arriving while a fetch is pending is queued. At most one is queued; a further tx_load holds tx_data stale.
- WRITE, on each rx_valid: in the same cycle mem_wdata <= rx_data and mem_we <= 1 (mem_we is 1 during the following cycle). mem_addr increments the cycle after mem_we. The write uses the pre-increment address.
- Address wrap: 2^ADDR_W-1 increments to 0, in both WRITE and READ.
- STATUS: tx_data = {err_cnt[6:0], 1'b1}, refreshed on every tx_load. rx bytes are ignored.
- DISCARD: all rx and tx_load are ignored; tx_data=8'hFF.
- tx_data=8'hFF in CMD, ADDR, WRITE and DISCARD, so the master reads 0xFF filler.
- sel falling in any state -> IDLE at the next clk:
  - mem_re and any pending fetch are cancelled;
  - a mem_we already asserted completes;
  - an rx_valid coincident with sel falling is still processed.
- A frame shorter than the CMD+ADDR bytes performs no memory access.
- reset mid-frame clears all state immediately (asynchronous). After reset, sel must go low then high before a new CMD is accepted, so the remainder of the interrupted frame is ignored.
- rx_valid and tx_load in the same cycle are both honoured.

Test Plan:
- Write burst: frame 53, 10, 8 random bytes -> 8 mem_we pulses at addresses 0x10..0x17 with matching data; no mem_re.
- Read burst: after the write burst, frame 4C, 10 plus 8 filler bytes -> MISO returns the same 8 bytes in order; mem_re at 0x10..0x17 (plus one prefetch at 0x18).
- Wrap: write 53, FE, AA, BB, CC -> memory[FE]=AA, [FF]=BB, [00]=CC.
- Bad command: frame 99, 01, 02 -> no memory access, err_cnt=1. Then frame 3F + 1 byte -> MISO 8'h03.
- Abort: frame 53, 20, 11, then sel drops, then new frame 4C, 20 -> first byte read is 11; busy=0 between frames.
- Reset mid-READ: assert reset during byte 3 -> all outputs at reset values; remaining bytes of the frame are ignored; the next frame operates normally.
